// File: rtl/servo_duty_ramp_if.sv
// servo_duty_ramp_if
//   Command-side bundle between the switch/hold sources and the duty ramp,
//   and the ramp's status/duty outputs toward pwm_generator.
//   sw          raw asynchronous switch bank (requested duty)
//   hold        1 = freeze the ramp in place
//   duty        slewed duty command
//   busy        1 while a ramp is in progress
//   at_target   1 when duty equals the debounced, clamped target
//   step_pulse  one-cycle pulse on every duty change
//   Modports: master drives sw/hold and observes the rest; slave is the ramp.
interface servo_duty_ramp_if;
    logic [3:0] sw;
    logic       hold;
    logic [3:0] duty;
    logic       busy;
    logic       at_target;
    logic       step_pulse;

    modport master (
        output sw, hold,
        input  duty, busy, at_target, step_pulse
    );

    modport slave (
        input  sw, hold,
        output duty, busy, at_target, step_pulse
    );
endinterface

// File: rtl/servo_duty_ramp.sv
// servo_duty_ramp
//   Command stage ahead of pwm_generator. Synchronises and debounces the 4-bit
//   switch bank, clamps it to [DUTY_MIN, DUTY_MAX] to form the target, then
//   slews duty toward the target one LSB every STEP_CYCLES clocks so the servo
//   never jumps.
//   Ports:
//     clk   system clock
//     rst   synchronous reset, active-high
//     bus   servo_duty_ramp_if.slave (sw, hold in; duty, busy, at_target,
//           step_pulse out)
module servo_duty_ramp #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned STEP_CYCLES     = 5000000,
    parameter logic [3:0]  DUTY_MIN        = 4'd2,
    parameter logic [3:0]  DUTY_MAX        = 4'd12,
    parameter logic [3:0]  DUTY_RESET      = 4'd7
) (
    input  logic              clk,
    input  logic              rst,
    servo_duty_ramp_if.slave  bus
);

    localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_e;

    function automatic logic [3:0] clamp(input logic [3:0] x);
        if (x < DUTY_MIN)      return DUTY_MIN;
        else if (x > DUTY_MAX) return DUTY_MAX;
        else                   return x;
    endfunction

    logic [3:0]        sync1_q, sync1_d;
    logic [3:0]        sw_s_q, sw_s_d;
    logic [3:0]        cand_q, cand_d;
    logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
    logic [3:0]        target_q, target_d;
    logic [3:0]        duty_q, duty_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    state_e            state_q, state_d;
    logic              busy_q, busy_d;
    logic              at_target_q, at_target_d;
    logic              step_pulse_q, step_pulse_d;

    // Synchroniser and whole-vector debounce. Any bit change restarts the
    // stability count; once stable, the clamped candidate is (re)loaded into
    // target every cycle with the counter parked at its last value.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        sync1_d   = bus.sw;
        sw_s_d    = sync1_q;
        cand_d    = cand_q;
        deb_cnt_d = deb_cnt_q;
        target_d  = target_q;
        if (sw_s_q != cand_q) begin
            cand_d    = sw_s_q;
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DEB_LAST) begin
            target_d = clamp(cand_q);
        end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
        end
    end

    // Ramp FSM: compares against the registered target each cycle.
    always_comb begin
        state_d      = state_q;
        duty_d       = duty_q;
        step_cnt_d   = step_cnt_q;
        step_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (target_q > duty_q) begin
                    state_d    = UP;
                    step_cnt_d = '0;
                end else if (target_q < duty_q) begin
                    state_d    = DOWN;
                    step_cnt_d = '0;
                end
            end
            UP, DOWN: begin
                // hold freezes everything in the ramp, including reaction to
                // a target change; it is re-evaluated once hold drops.
                if (!bus.hold) begin
                    if (target_q == duty_q) begin
                        state_d = IDLE;
                    end else if ((state_q == UP) != (target_q > duty_q)) begin
                        // Direction reversal: restart the step interval.
                        state_d    = (target_q > duty_q) ? UP : DOWN;
                        step_cnt_d = '0;
                    end else if (step_cnt_q == STEP_LAST) begin
                        duty_d       = (state_q == UP) ? duty_q + 4'd1 : duty_q - 4'd1;
                        step_cnt_d   = '0;
                        step_pulse_d = 1'b1;
                        if (duty_d == target_q) state_d = IDLE;
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Status flags are registered from next-state values so they line up
        // with the duty/target they describe.
        busy_d      = (state_d != IDLE);
        at_target_d = (duty_d == target_d);
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            sync1_q      <= '0;
            sw_s_q       <= '0;
            cand_q       <= '0;
            deb_cnt_q    <= '0;
            target_q     <= DUTY_RESET;
            duty_q       <= DUTY_RESET;
            step_cnt_q   <= '0;
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            at_target_q  <= 1'b1;
            step_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sw_s_q       <= sw_s_d;
            cand_q       <= cand_d;
            deb_cnt_q    <= deb_cnt_d;
            target_q     <= target_d;
            duty_q       <= duty_d;
            step_cnt_q   <= step_cnt_d;
            state_q      <= state_d;
            busy_q       <= busy_d;
            at_target_q  <= at_target_d;
            step_pulse_q <= step_pulse_d;
        end
    end

    assign bus.duty       = duty_q;
    assign bus.busy       = busy_q;
    assign bus.at_target  = at_target_q;
    assign bus.step_pulse = step_pulse_q;

endmodule

// File: tb/tb_servo_duty_ramp.sv
// tb_servo_duty_ramp
//   Self-checking bench for servo_duty_ramp with short debounce/step intervals.
//   Inputs are driven 1 ns after the rising edge and outputs sampled there.
module tb_servo_duty_ramp;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    servo_duty_ramp_if bus ();

    servo_duty_ramp #(
        .DEBOUNCE_CYCLES (4),
        .STEP_CYCLES     (3),
        .DUTY_MIN        (4'd2),
        .DUTY_MAX        (4'd12),
        .DUTY_RESET      (4'd7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       rst;
        logic [3:0] sw;
        logic       hold;
        logic [3:0] duty;
        logic       busy;
        logic       at;
        logic       pulse;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;
    int   pulses;
    int   dmin;
    int   dmax;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        pulses += int'(bus.step_pulse);
        if (int'(bus.duty) < dmin) dmin = int'(bus.duty);
        if (int'(bus.duty) > dmax) dmax = int'(bus.duty);
    endtask

    function automatic void add(input logic r, input logic [3:0] s, input logic [3:0] d,
                                input logic b, input logic a, input logic p);
        vec_t v;
        v.rst = r; v.sw = s; v.hold = 1'b0;
        v.duty = d; v.busy = b; v.at = a; v.pulse = p;
        vecs.push_back(v);
    endfunction

    // Tick until duty == d (and idle if requested), bounded by budget.
    task automatic wait_duty(input logic [3:0] d, input bit idle, input int budget, input string name);
        int n = 0;
        while (!(bus.duty === d && (!idle || bus.busy === 1'b0)) && n < budget) begin
            tick();
            n++;
        end
        check({name, ".duty"}, bus.duty, d);
        if (idle) begin
            check({name, ".busy"}, bus.busy, 0);
            check({name, ".at_target"}, bus.at_target, 1);
        end
    endtask

    initial begin
        logic [3:0] rev_duty [11];
        logic       rev_pulse [11];
        int glitches;
        int n;

        rev_duty  = '{4'd4, 4'd4, 4'd5, 4'd5, 4'd5, 4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd5};
        rev_pulse = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        pulses = 0; dmin = 15; dmax = 0;
        rst = 1'b1; bus.sw = 4'hF; bus.hold = 1'b0;

        // Reset with sw=F, then idle at sw=7, then a clean step to 10.
        add(1, 4'hF, 4'd7, 0, 1, 0);
        add(1, 4'hF, 4'd7, 0, 1, 0);
        for (int i = 0; i < 8; i++) add(0, 4'd7, 4'd7, 0, 1, 0);
        for (int i = 0; i < 6; i++) add(0, 4'd10, 4'd7, 0, 1, 0);
        add(0, 4'd10, 4'd7,  0, 0, 0);
        add(0, 4'd10, 4'd7,  1, 0, 0);
        add(0, 4'd10, 4'd7,  1, 0, 0);
        add(0, 4'd10, 4'd7,  1, 0, 0);
        add(0, 4'd10, 4'd8,  1, 0, 1);
        add(0, 4'd10, 4'd8,  1, 0, 0);
        add(0, 4'd10, 4'd8,  1, 0, 0);
        add(0, 4'd10, 4'd9,  1, 0, 1);
        add(0, 4'd10, 4'd9,  1, 0, 0);
        add(0, 4'd10, 4'd9,  1, 0, 0);
        add(0, 4'd10, 4'd10, 0, 1, 1);
        add(0, 4'd10, 4'd10, 0, 1, 0);

        foreach (vecs[i]) begin
            rst      = vecs[i].rst;
            bus.sw   = vecs[i].sw;
            bus.hold = vecs[i].hold;
            tick();
            check($sformatf("vec%0d.duty", i),       bus.duty,       vecs[i].duty);
            check($sformatf("vec%0d.busy", i),       bus.busy,       vecs[i].busy);
            check($sformatf("vec%0d.at_target", i),  bus.at_target,  vecs[i].at);
            check($sformatf("vec%0d.step_pulse", i), bus.step_pulse, vecs[i].pulse);
        end

        // Bounce: bit0 toggles every 2 clocks, never stable long enough.
        glitches = 0;
        for (int i = 0; i < 10; i++) begin
            bus.sw = (i % 2 == 0) ? 4'd9 : 4'd8;
            repeat (2) begin
                tick();
                if (bus.at_target !== 1'b1 || bus.busy !== 1'b0 || bus.duty !== 4'd10) glitches++;
            end
        end
        check("bounce.no_target_change", glitches, 0);
        bus.sw = 4'd9;
        for (int k = 1; k <= 11; k++) begin
            tick();
            check($sformatf("settle%0d.at_target", k), bus.at_target, (k <= 6 || k == 11) ? 1 : 0);
            check($sformatf("settle%0d.duty", k), bus.duty, (k == 11) ? 9 : 10);
        end

        // Clamp low: 0 -> target 2, seven steps down from 9.
        bus.sw = 4'd0; pulses = 0; dmin = 15;
        wait_duty(4'd2, 1, 100, "clamp_low");
        check("clamp_low.pulses", pulses, 7);
        repeat (5) tick();
        check("clamp_low.min", dmin, 2);
        check("clamp_low.stays", bus.duty, 2);

        // Clamp high: 15 -> target 12, ten steps up from 2.
        bus.sw = 4'd15; pulses = 0; dmax = 0;
        wait_duty(4'd12, 1, 150, "clamp_high");
        check("clamp_high.pulses", pulses, 10);
        repeat (5) tick();
        check("clamp_high.max", dmax, 12);
        check("clamp_high.stays", bus.duty, 12);

        // Reversal: go low, ramp up, request 3 while at duty 4 so the new
        // target lands while duty is 6 partway into a step interval.
        bus.sw = 4'd0;
        wait_duty(4'd2, 1, 150, "rev_setup");
        bus.sw = 4'd15;
        wait_duty(4'd4, 0, 100, "rev_reach4");
        bus.sw = 4'd3;
        for (int k = 0; k < 11; k++) begin
            tick();
            check($sformatf("rev%0d.duty", k + 1), bus.duty, rev_duty[k]);
            check($sformatf("rev%0d.pulse", k + 1), bus.step_pulse, rev_pulse[k]);
            check($sformatf("rev%0d.busy", k + 1), bus.busy, 1);
        end
        wait_duty(4'd3, 1, 50, "rev_end");

        // Hold mid-ramp: freeze with one count consumed, then finish the interval.
        bus.sw = 4'd9;
        n = 0;
        while (bus.busy !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("hold.enter_up", bus.busy, 1);
        tick();
        bus.hold = 1'b1;
        glitches = 0;
        repeat (10) begin
            tick();
            if (bus.duty !== 4'd3 || bus.step_pulse !== 1'b0 || bus.busy !== 1'b1) glitches++;
        end
        check("hold.frozen", glitches, 0);
        bus.hold = 1'b0;
        tick();
        check("hold.resume1.duty", bus.duty, 3);
        tick();
        check("hold.resume2.duty", bus.duty, 4);
        check("hold.resume2.pulse", bus.step_pulse, 1);

        // Reset mid-ramp: snap back to centre on the next edge.
        tick();
        rst = 1'b1;
        tick();
        check("rst_mid.duty", bus.duty, 7);
        check("rst_mid.busy", bus.busy, 0);
        check("rst_mid.at_target", bus.at_target, 1);
        check("rst_mid.pulse", bus.step_pulse, 0);
        rst = 1'b0;
        tick();
        check("rst_mid.after.duty", bus.duty, 7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
